// File: rtl/uart_pixel_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pixel_rx
//  Purpose  : 8N1 UART receiver (LSB first) that assembles BPP consecutive
//             bytes into one SZ-bit pixel word. It emits a one-cycle done
//             strobe per pixel and a one-cycle strobe per framing error.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_pixel_rx #(
   parameter int BPP          = 3,
   parameter int SZ           = 8 * BPP,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          data_rx,
   output logic [SZ-1:0] data_out,
   output logic          done_flag,
   output logic          active_flag,
   output logic          error_flag
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] c_TICK_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] c_TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [1:0]    c_LAST_BYTE = 2'(BPP - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_STOP      = 3'd3,
      S_WAIT_IDLE = 3'd4
   } state_t;

   state_t          r_state;
   logic [1:0]      r_sync;
   logic [TW-1:0]   r_tick;
   logic [2:0]      r_bit_idx;
   logic [1:0]      r_byte_idx;
   logic [7:0]      r_shift;
   logic [SZ-1:0]   r_pixel;
   logic [SZ-1:0]   w_pixel_next;
   logic            w_rx_s;

   assign w_rx_s = r_sync[1];

   // Two-flop synchroniser; the line idles high, so reset to ones.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], data_rx};
      end
   end

   // Pixel buffer with the just-received byte dropped into the current slot.
   always_comb begin
      w_pixel_next = r_pixel;
      for (int i = 0; i < BPP; i++) begin
         if (r_byte_idx == 2'(i)) begin
            w_pixel_next[8*i +: 8] = r_shift;
         end
      end
   end

   // Receive FSM: bit timing, byte assembly, pixel hand-off and error flags.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_tick      <= '0;
         r_bit_idx   <= '0;
         r_byte_idx  <= '0;
         r_shift     <= '0;
         r_pixel     <= '0;
         data_out    <= '0;
         done_flag   <= 1'b0;
         active_flag <= 1'b0;
         error_flag  <= 1'b0;
      end else begin
         done_flag  <= 1'b0;
         error_flag <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // No dead cycles here so a back-to-back start bit is caught.
               if (!w_rx_s) begin
                  r_state     <= S_START;
                  r_tick      <= '0;
                  active_flag <= 1'b1;
               end
            end
            S_START: begin
               if (r_tick == c_TICK_HALF) begin
                  if (!w_rx_s) begin
                     r_state   <= S_DATA;
                     r_tick    <= '0;
                     r_bit_idx <= '0;
                  end else begin
                     // Start bit did not hold to mid-bit: treat as a glitch.
                     r_state     <= S_IDLE;
                     active_flag <= 1'b0;
                  end
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            S_DATA: begin
               if (r_tick == c_TICK_LAST) begin
                  r_tick             <= '0;
                  r_shift[r_bit_idx] <= w_rx_s;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            S_STOP: begin
               if (r_tick == c_TICK_LAST) begin
                  r_tick      <= '0;
                  active_flag <= 1'b0;
                  if (w_rx_s) begin
                     r_pixel <= w_pixel_next;
                     r_state <= S_IDLE;
                     if (r_byte_idx == c_LAST_BYTE) begin
                        data_out   <= w_pixel_next;
                        done_flag  <= 1'b1;
                        r_byte_idx <= '0;
                     end else begin
                        r_byte_idx <= r_byte_idx + 1'b1;
                     end
                  end else begin
                     // Framing error: drop the partial pixel, keep data_out.
                     error_flag <= 1'b1;
                     r_byte_idx <= '0;
                     r_state    <= S_WAIT_IDLE;
                  end
               end else begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            S_WAIT_IDLE: begin
               // A held-low break must not retrigger, so wait for idle high.
               if (w_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               active_flag <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_pixel_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_pixel_rx
//  Purpose  : Self-checking bench for uart_pixel_rx with a pixel scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_pixel_rx;

   localparam int BPP = 3;
   localparam int SZ  = 8 * BPP;
   localparam int CPB = 16;

   logic          clock   = 1'b0;
   logic          reset_n = 1'b0;
   logic          data_rx = 1'b1;
   logic [SZ-1:0] data_out;
   logic          done_flag;
   logic          active_flag;
   logic          error_flag;

   int checks = 0;
   int errors = 0;

   logic [SZ-1:0] exp_q[$];
   int            exp_err    = 0;
   int            cycle      = 0;
   int            done_cycle = -1000;
   int            stop_cycle = 0;
   int            act_cnt    = 0;
   logic [SZ-1:0] last_out   = '0;
   logic [SZ-1:0] mon_exp;
   logic          prev_done  = 1'b0;

   uart_pixel_rx #(
      .BPP          (BPP),
      .SZ           (SZ),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .data_rx     (data_rx),
      .data_out    (data_out),
      .done_flag   (done_flag),
      .active_flag (active_flag),
      .error_flag  (error_flag)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycle++;

   // Monitor: pops the scoreboard on each done pulse, tracks error pulses.
   always @(negedge clock) begin
      if (!reset_n) begin
         last_out  = data_out;
         prev_done = 1'b0;
      end else begin
         if (done_flag) begin
            done_cycle = cycle;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected: data_out=%h, no pixel pending", data_out);
            end else begin
               mon_exp = exp_q.pop_front();
               if (data_out !== mon_exp) begin
                  errors++;
                  $display("FAIL pixel: got %h expected %h", data_out, mon_exp);
               end
            end
            checks++;
            if (error_flag) begin
               errors++;
               $display("FAIL done_with_error: error_flag=%b expected 0", error_flag);
            end
            checks++;
            if (prev_done) begin
               errors++;
               $display("FAIL done_consecutive: prev_done=%b expected 0", prev_done);
            end
         end else if (data_out !== last_out) begin
            checks++;
            errors++;
            $display("FAIL data_out_unstable: got %h expected %h", data_out, last_out);
         end
         if (error_flag) begin
            checks++;
            if (exp_err == 0) begin
               errors++;
               $display("FAIL error_unexpected: error_flag=1 expected 0");
            end else begin
               exp_err--;
            end
         end
         last_out  = data_out;
         prev_done = done_flag;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One 8N1 frame; stop selects a good (1) or bad (0) stop bit.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      if (!stop) exp_err++;
      data_rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         data_rx = b[i];
         idle(CPB / 2);
         if (i == 4) check("active_mid_frame", {31'd0, active_flag}, 32'd1);
         idle(CPB / 2);
      end
      stop_cycle = cycle;
      data_rx    = stop;
      idle(CPB);
   endtask

   task automatic send_pixel(input logic [SZ-1:0] p);
      exp_q.push_back(p);
      for (int k = 0; k < BPP; k++) send_byte(p[8*k +: 8], 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset hold, then quiet line
      data_rx = 1'b1;
      reset_n = 1'b0;
      idle(10);
      check("rst_data_out", data_out, 32'd0);
      check("rst_done", {31'd0, done_flag}, 32'd0);
      check("rst_active", {31'd0, active_flag}, 32'd0);
      check("rst_error", {31'd0, error_flag}, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clock);
         if (active_flag) act_cnt++;
      end
      check("idle_active_cycles", act_cnt, 32'd0);
      check("idle_data_out", data_out, 32'd0);

      // 2: back-to-back pixel
      send_pixel(24'h0F55AA);
      idle(2 * CPB);
      check("pixel2_consumed", exp_q.size(), 32'd0);
      check("done_latency_ok",
            {31'd0, ((done_cycle - stop_cycle) >= 9) && ((done_cycle - stop_cycle) <= 13)},
            32'd1);
      check("pixel2_data_out", data_out, 32'h0F55AA);

      // 3: framing error drops the partial pixel
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      data_rx = 1'b1;
      idle(3 * CPB);
      check("framing_error_seen", exp_err, 32'd0);
      check("error_keeps_data_out", data_out, 32'h0F55AA);
      send_pixel(24'h665544);
      idle(2 * CPB);
      check("pixel3_consumed", exp_q.size(), 32'd0);
      check("pixel3_data_out", data_out, 32'h665544);

      // 4: glitch between bytes of a pixel, with an idle gap
      exp_q.push_back(24'h998877);
      send_byte(8'h77, 1'b1);
      idle(2 * CPB);
      data_rx = 1'b0;
      idle(4);
      data_rx = 1'b1;
      idle(3 * CPB);
      check("glitch_inactive", {31'd0, active_flag}, 32'd0);
      send_byte(8'h88, 1'b1);
      send_byte(8'h99, 1'b1);
      idle(2 * CPB);
      check("pixel4_consumed", exp_q.size(), 32'd0);
      check("pixel4_data_out", data_out, 32'h998877);

      // 5: reset in the middle of the second byte
      send_byte(8'hAB, 1'b1);
      data_rx = 1'b0;
      idle(CPB);
      data_rx = 1'b1;
      idle(CPB);
      data_rx = 1'b0;
      idle(CPB / 2);
      reset_n = 1'b0;
      idle(5);
      data_rx = 1'b1;
      check("midreset_data_out", data_out, 32'd0);
      check("midreset_active", {31'd0, active_flag}, 32'd0);
      reset_n = 1'b1;
      idle(2 * CPB);
      send_pixel(24'h030201);
      idle(2 * CPB);
      check("pixel5_consumed", exp_q.size(), 32'd0);
      check("pixel5_data_out", data_out, 32'h030201);

      // 6: break condition
      exp_err++;
      data_rx = 1'b0;
      idle(40 * CPB);
      check("break_inactive", {31'd0, active_flag}, 32'd0);
      check("break_one_error", exp_err, 32'd0);
      check("break_keeps_data_out", data_out, 32'h030201);
      data_rx = 1'b1;
      idle(2 * CPB);
      check("break_still_one_error", exp_err, 32'd0);
      send_pixel(24'hC3B2A1);
      idle(2 * CPB);
      check("pixel6_consumed", exp_q.size(), 32'd0);
      check("pixel6_data_out", data_out, 32'hC3B2A1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
